pipe_id_exe_reg: RTL

//  ID->EXE pipeline register; producer side of the EXE stage operand/control bundle.

---
 rtl/pipe_id_exe_reg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_id_exe_reg.sv
// ID->EXE pipeline register with EXE/MEM operand forwarding, load-use stall and flush kill.
// Control fields are cleared on bubbles; the datapath fields always load because they are
// don't-care while evalid is low.
module pipe_id_exe_reg #(
  parameter logic [3:0] BUBBLE_ALUC = 4'b0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dvalid,
  input  logic        dwreg,
  input  logic        dm2reg,
  input  logic        dwmem,
  input  logic        djal,
  input  logic        daluimm,
  input  logic        dshift,
  input  logic [3:0]  daluc,
  input  logic [31:0] da,
  input  logic [31:0] db,
  input  logic [31:0] dimm,
  input  logic [31:0] dpc4,
  input  logic [4:0]  drs,
  input  logic [4:0]  drt,
  input  logic        duse_rs,
  input  logic        duse_rt,
  input  logic [4:0]  drn,
  input  logic [31:0] ealu,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic [4:0]  mrn,
  input  logic [31:0] malu,
  input  logic [31:0] mmo,
  input  logic        flush,
  output logic        stall,
  output logic        evalid,
  output logic        ewreg,
  output logic        em2reg,
  output logic        ewmem,
  output logic        ejal,
  output logic        ealuimm,
  output logic        eshift,
  output logic [3:0]  ealuc,
  output logic [31:0] ea,
  output logic [31:0] eb,
  output logic [31:0] eimm,
  output logic [31:0] epc4,
  output logic [4:0]  ern0
);

  logic        evalid_q, evalid_d;
  logic        ewreg_q, ewreg_d;
  logic        em2reg_q, em2reg_d;
  logic        ewmem_q, ewmem_d;
  logic        ejal_q, ejal_d;
  logic        ealuimm_q, ealuimm_d;
  logic        eshift_q, eshift_d;
  logic [3:0]  ealuc_q, ealuc_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] eb_q, eb_d;
  logic [31:0] eimm_q, eimm_d;
  logic [31:0] epc4_q, epc4_d;
  logic [4:0]  ern0_q, ern0_d;

  logic [4:0]  ern;
  logic        e_wr;
  logic        e_fwd;
  logic        m_wr;
  logic [31:0] m_val;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        hazard;
  logic        load;

  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  src,
    input logic [31:0] rf,
    input logic        e_ok,
    input logic [4:0]  e_rn,
    input logic [31:0] e_val,
    input logic        m_ok,
    input logic [4:0]  m_rn,
    input logic [31:0] m_v
  );
    if (e_ok && (e_rn == src)) begin
      return e_val;
    end
    if (m_ok && (m_rn == src)) begin
      return m_v;
    end
    return rf;
  endfunction

  // jal writes r31 regardless of the decoded destination.
  assign ern   = ern0_q | {5{ejal_q}};
  assign e_wr  = evalid_q & ewreg_q & (ern != 5'd0);
  // A load in EXE has no data yet, so it can only stall, never forward.
  assign e_fwd = e_wr & ~em2reg_q;
  assign m_wr  = mwreg & (mrn != 5'd0);
  assign m_val = mm2reg ? mmo : malu;

  always_comb begin
    fwd_a = fwd_sel(drs, da, e_fwd, ern, ealu, m_wr, mrn, m_val);
    fwd_b = fwd_sel(drt, db, e_fwd, ern, ealu, m_wr, mrn, m_val);
  end

  assign hazard = dvalid & e_wr & em2reg_q &
                  ((duse_rs & (ern == drs)) | (duse_rt & (ern == drt)));
  assign stall  = hazard & ~flush;
  assign load   = dvalid & ~flush & ~hazard;

  always_comb begin
    evalid_d  = 1'b0;
    ewreg_d   = 1'b0;
    em2reg_d  = 1'b0;
    ewmem_d   = 1'b0;
    ejal_d    = 1'b0;
    ealuimm_d = 1'b0;
    eshift_d  = 1'b0;
    ealuc_d   = BUBBLE_ALUC;
    ea_d      = fwd_a;
    eb_d      = fwd_b;
    eimm_d    = dimm;
    epc4_d    = dpc4;
    ern0_d    = drn;
    if (load) begin
      evalid_d  = 1'b1;
      ewreg_d   = dwreg;
      em2reg_d  = dm2reg;
      ewmem_d   = dwmem;
      ejal_d    = djal;
      ealuimm_d = daluimm;
      eshift_d  = dshift;
      ealuc_d   = daluc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      evalid_q  <= 1'b0;
      ewreg_q   <= 1'b0;
      em2reg_q  <= 1'b0;
      ewmem_q   <= 1'b0;
      ejal_q    <= 1'b0;
      ealuimm_q <= 1'b0;
      eshift_q  <= 1'b0;
      ealuc_q   <= BUBBLE_ALUC;
      ea_q      <= 32'd0;
      eb_q      <= 32'd0;
      eimm_q    <= 32'd0;
      epc4_q    <= 32'd0;
      ern0_q    <= 5'd0;
    end else begin
      evalid_q  <= evalid_d;
      ewreg_q   <= ewreg_d;
      em2reg_q  <= em2reg_d;
      ewmem_q   <= ewmem_d;
      ejal_q    <= ejal_d;
      ealuimm_q <= ealuimm_d;
      eshift_q  <= eshift_d;
      ealuc_q   <= ealuc_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      eimm_q    <= eimm_d;
      epc4_q    <= epc4_d;
      ern0_q    <= ern0_d;
    end
  end

  assign evalid  = evalid_q;
  assign ewreg   = ewreg_q;
  assign em2reg  = em2reg_q;
  assign ewmem   = ewmem_q;
  assign ejal    = ejal_q;
  assign ealuimm = ealuimm_q;
  assign eshift  = eshift_q;
  assign ealuc   = ealuc_q;
  assign ea      = ea_q;
  assign eb      = eb_q;
  assign eimm    = eimm_q;
  assign epc4    = epc4_q;
  assign ern0    = ern0_q;

endmodule
